data_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port data memory of the pipeline. It shares the memory between the MEM stage (port 0) and the debug/loader unit (port 1), using round-robin arbitration. It also drives the memory's control signals, which write on the falling clock edge and read on the rising edge. It holds the MEM stage through `p0_stall` until its access completes.

---
 rtl/data_mem_arbiter.sv | 106 ++++++++++
 tb/tb_data_mem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one single-port data memory between the MEM stage (port 0) and
//   the debug/loader unit (port 1) with round-robin arbitration. Every access
//   runs IDLE -> ACCESS -> RESP. The memory writes on the falling edge and
//   reads on the rising edge inside ACCESS, so both finish by RESP.
//
// Ports
//   clock, reset            : single clock, synchronous active-high reset
//   pN_req/we/addr/wdata    : request side, req held high until pN_ack
//   pN_rdata, pN_ack        : read data and one-cycle completion pulse (RESP)
//   p0_stall                : holds the MEM stage while its access is pending
//   busy                    : FSM not idle
//   mem_address/in_data     : registered address / write data to the memory
//   mem_write/mem_read      : memory strobes, high only during ACCESS
//   mem_out_data            : read data returned by the memory
module data_mem_arbiter #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic [DATA_W-1:0] p0_rdata,
   output logic              p0_ack,
   output logic              p0_stall,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              p1_ack,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_in_data,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_out_data
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state, state_n;
   logic                gnt, last, we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                any_req, gnt_n;

   // Under contention the port that was not served last wins; a lone
   // requester always wins.
   always_comb begin
      any_req = p0_req | p1_req;
      if (p0_req && p1_req)
         gnt_n = ~last;
      else
         gnt_n = p1_req;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (any_req) state_n = ACCESS;
         ACCESS:  state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         gnt     <= 1'b0;
         last    <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && any_req) begin
            gnt     <= gnt_n;
            last    <= gnt_n;
            we_q    <= gnt_n ? p1_we    : p0_we;
            addr_q  <= gnt_n ? p1_addr  : p0_addr;
            wdata_q <= gnt_n ? p1_wdata : p0_wdata;
         end
      end
   end

   // Address and write data stay on the registered copy in every state so
   // the memory inputs never glitch; only the strobes are qualified.
   always_comb begin
      busy        = (state != IDLE);
      mem_address = addr_q;
      mem_in_data = wdata_q;
      mem_write   = (state == ACCESS) &&  we_q;
      mem_read    = (state == ACCESS) && !we_q;
      p0_ack      = (state == RESP) && !gnt;
      p1_ack      = (state == RESP) &&  gnt;
      p0_rdata    = (p0_ack && !we_q) ? mem_out_data : '0;
      p1_rdata    = (p1_ack && !we_q) ? mem_out_data : '0;
      p0_stall    = p0_req && !p0_ack;
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 32;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              p0_req = 1'b0, p0_we = 1'b0;
   logic [ADDR_W-1:0] p0_addr = '0;
   logic [DATA_W-1:0] p0_wdata = '0;
   logic              p1_req = 1'b0, p1_we = 1'b0;
   logic [ADDR_W-1:0] p1_addr = '0;
   logic [DATA_W-1:0] p1_wdata = '0;
   logic [DATA_W-1:0] p0_rdata, p1_rdata;
   logic              p0_ack, p1_ack, p0_stall, busy;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_in_data;
   logic              mem_write, mem_read;
   logic [DATA_W-1:0] mem_out_data = '0;

   int checks = 0;
   int errors = 0;

   data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock(clock), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_stall(p0_stall),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_rdata(p1_rdata), .p1_ack(p1_ack), .busy(busy),
      .mem_address(mem_address), .mem_in_data(mem_in_data),
      .mem_write(mem_write), .mem_read(mem_read), .mem_out_data(mem_out_data)
   );

   always #5 clock = ~clock;

   // Memory model: preload pattern 0x1000_0000|addr (addr 5 = DEADBEEF),
   // write on negedge, read latched on posedge.
   logic [DATA_W-1:0] mem [0:2047];
   bit loaded = 1'b0;
   always @(negedge clock) begin
      if (!loaded) begin
         for (int i = 0; i < 2048; i++) mem[i] <= 32'h1000_0000 | i;
         mem[5] <= 32'hDEAD_BEEF;
         loaded <= 1'b1;
      end else if (mem_write) begin
         mem[mem_address] <= mem_in_data;
      end
   end
   always @(posedge clock) if (mem_read) mem_out_data <= mem[mem_address];

   typedef struct {bit port; bit we; logic [DATA_W-1:0] rdata;} sb_t;
   sb_t sb[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Scoreboard and per-cycle invariants.
   always @(negedge clock) begin
      if (!reset) begin
         check("stall_rule", {63'd0, p0_stall}, {63'd0, p0_req & ~p0_ack});
         check("strobe_outside_access", {63'd0, (mem_read | mem_write) & (~busy | p0_ack | p1_ack)}, 64'd0);
      end
      if (p0_ack || p1_ack) begin
         check("single_ack", {63'd0, p0_ack & p1_ack}, 64'd0);
         if (sb.size() == 0) begin
            check("unexpected_ack", {63'd0, p1_ack}, {63'd0, ~p1_ack});
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("ack_port", {63'd0, p1_ack}, {63'd0, e.port});
            if (!e.we)
               check("rdata", {32'd0, e.port ? p1_rdata : p0_rdata}, {32'd0, e.rdata});
            check("other_rdata_zero", {32'd0, e.port ? p0_rdata : p1_rdata}, 64'd0);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clock); #1;
   endtask

   task automatic set_port(input bit port, input bit req, input bit we,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      if (port) begin p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d; end
      else      begin p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d; end
   endtask

   // Issues one request from IDLE and checks ack arrives two cycles later.
   task automatic do_txn(input bit port, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp);
      int n = 0;
      bit got = 0;
      sb.push_back('{port, we, exp});
      set_port(port, 1'b1, we, a, d);
      while (!got && n < 10) begin
         @(negedge clock);
         if (port ? p1_ack : p0_ack) got = 1; else n++;
      end
      check("ack_latency", {63'd0, got}, 64'd1);
      check("ack_cycle", n, 2);
      next_cycle();
      set_port(port, 1'b0, we, a, d);
   endtask

   typedef struct {bit port; bit we; logic [ADDR_W-1:0] addr;
                   logic [DATA_W-1:0] wdata; logic [DATA_W-1:0] exp;} vec_t;
   vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{0, 0, 11'd5,    32'h0,         32'hDEAD_BEEF};
      vecs[1] = '{1, 1, 11'd2047, 32'h1234_5678, 32'h0};
      vecs[2] = '{1, 0, 11'd2047, 32'h0,         32'h1234_5678};
      vecs[3] = '{0, 1, 11'd0,    32'hCAFE_F00D, 32'h0};
      vecs[4] = '{1, 0, 11'd0,    32'h0,         32'hCAFE_F00D};
      vecs[5] = '{0, 0, 11'd2047, 32'h0,         32'h1234_5678};

      // Reset with both requests present: reset wins.
      p0_req = 1; p1_req = 1;
      repeat (3) next_cycle();
      @(negedge clock);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_acks", {62'd0, p1_ack, p0_ack}, 64'd0);
      check("rst_strobes", {62'd0, mem_write, mem_read}, 64'd0);
      check("rst_rdata", {p1_rdata, p0_rdata}, 64'd0);
      check("rst_addr", {53'd0, mem_address}, 64'd0);
      check("rst_stall", {63'd0, p0_stall}, 64'd1);
      next_cycle();
      reset = 0; p0_req = 0; p1_req = 0;
      @(negedge clock);
      check("post_rst_idle", {63'd0, busy}, 64'd0);
      next_cycle();

      // Contention right after reset: grants 0,1,0,1 with acks at 2,5,8,11.
      for (int k = 0; k < 2; k++) begin
         sb.push_back('{0, 0, 32'h1000_000A});
         sb.push_back('{1, 0, 32'h1000_0014});
      end
      set_port(0, 1, 0, 11'd10, 32'h0);
      set_port(1, 1, 0, 11'd20, 32'h0);
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clock);
         check("cont_p0_ack", {63'd0, p0_ack}, {63'd0, cyc == 2 || cyc == 8});
         check("cont_p1_ack", {63'd0, p1_ack}, {63'd0, cyc == 5 || cyc == 11});
         next_cycle();
      end
      p0_req = 0; p1_req = 0;
      next_cycle();

      // Single read with stall and strobe timing.
      sb.push_back('{0, 0, 32'hDEAD_BEEF});
      set_port(0, 1, 0, 11'd5, 32'h0);
      @(negedge clock);
      check("sr_stall_c0", {63'd0, p0_stall}, 64'd1);
      next_cycle(); @(negedge clock);
      check("sr_read_c1", {63'd0, mem_read}, 64'd1);
      check("sr_addr_c1", {53'd0, mem_address}, 64'd5);
      check("sr_stall_c1", {63'd0, p0_stall}, 64'd1);
      next_cycle(); @(negedge clock);
      check("sr_ack_c2", {63'd0, p0_ack}, 64'd1);
      check("sr_stall_c2", {63'd0, p0_stall}, 64'd0);
      next_cycle();
      p0_req = 0;
      next_cycle();

      // Table-driven transactions.
      for (int i = 0; i < 6; i++)
         do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

      // Held request: back-to-back acks every 3 cycles.
      for (int k = 0; k < 3; k++) sb.push_back('{0, 0, 32'hDEAD_BEEF});
      set_port(0, 1, 0, 11'd5, 32'h0);
      for (int cyc = 0; cyc < 9; cyc++) begin
         @(negedge clock);
         check("held_ack", {63'd0, p0_ack}, {63'd0, cyc % 3 == 2});
         next_cycle();
      end
      p0_req = 0;
      next_cycle();

      // Reset during a read ACCESS: no ack, back to idle.
      set_port(0, 1, 0, 11'd5, 32'h0);
      next_cycle();
      reset = 1;
      @(negedge clock);
      check("rr_read_c1", {63'd0, mem_read}, 64'd1);
      next_cycle();
      reset = 0; p0_req = 0;
      @(negedge clock);
      check("rr_no_ack", {63'd0, p0_ack}, 64'd0);
      check("rr_busy", {63'd0, busy}, 64'd0);
      check("rr_read_c2", {63'd0, mem_read}, 64'd0);
      next_cycle();

      // Reset during a write ACCESS: no ack, but the write still lands.
      set_port(0, 1, 1, 11'd7, 32'hA5A5_A5A5);
      next_cycle();
      reset = 1;
      @(negedge clock);
      check("rw_write_c1", {63'd0, mem_write}, 64'd1);
      next_cycle();
      reset = 0; p0_req = 0;
      @(negedge clock);
      check("rw_no_ack", {63'd0, p0_ack}, 64'd0);
      check("rw_busy", {63'd0, busy}, 64'd0);
      next_cycle();
      do_txn(0, 0, 11'd7, 32'h0, 32'hA5A5_A5A5);

      repeat (2) next_cycle();
      check("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
